// File: rtl/regfile_write_sched.sv
// Write-port scheduler for the 2R/1W register file: zero-fills every entry after reset or
// reinit, then arbitrates two writeback requesters round-robin into one registered write.
module regfile_write_sched #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iReinit,
  input  logic                  iValid0,
  input  logic [ADDR_WIDTH-1:0] iAddr0,
  input  logic [DATA_WIDTH-1:0] iData0,
  output logic                  oReady0,
  input  logic                  iValid1,
  input  logic [ADDR_WIDTH-1:0] iAddr1,
  input  logic [DATA_WIDTH-1:0] iData1,
  output logic                  oReady1,
  output logic                  oEnWrite,
  output logic [ADDR_WIDTH-1:0] oAddrWrite,
  output logic [DATA_WIDTH-1:0] oDataWrite,
  output logic                  oInitDone
);

  typedef enum logic [0:0] {StInit, StRun} stateE;

  stateE                 stateQ, stateD;
  logic [ADDR_WIDTH:0]   fillCntQ, fillCntD;
  logic                  ptrQ, ptrD;
  logic                  enQ, enD;
  logic [ADDR_WIDTH-1:0] addrQ, addrD;
  logic [DATA_WIDTH-1:0] dataQ, dataD;
  logic                  run;

  assign run = (stateQ == StRun);

  // Pointer holds the last granted requester; on contention the other one wins.
  assign oReady0 = run & iValid0 & (~iValid1 | ptrQ);
  assign oReady1 = run & iValid1 & (~iValid0 | ~ptrQ);

  always_comb begin
    stateD   = stateQ;
    fillCntD = fillCntQ;
    ptrD     = ptrQ;
    enD      = 1'b0;
    addrD    = addrQ;
    dataD    = dataQ;
    if (iReinit) begin
      // The reinit edge itself issues fill address 0; any concurrent transfer is dropped.
      stateD   = StInit;
      enD      = 1'b1;
      addrD    = '0;
      dataD    = '0;
      fillCntD = {{ADDR_WIDTH{1'b0}}, 1'b1};
    end else begin
      unique case (stateQ)
        StInit: begin
          // The extra counter bit sets exactly when every address has been issued.
          if (fillCntQ[ADDR_WIDTH]) begin
            stateD = StRun;
          end else begin
            enD      = 1'b1;
            addrD    = fillCntQ[ADDR_WIDTH-1:0];
            dataD    = '0;
            fillCntD = fillCntQ + 1'b1;
          end
        end
        StRun: begin
          if (oReady0) begin
            ptrD = 1'b0;
            if (iAddr0 != '0) begin
              enD   = 1'b1;
              addrD = iAddr0;
              dataD = iData0;
            end
          end else if (oReady1) begin
            ptrD = 1'b1;
            if (iAddr1 != '0) begin
              enD   = 1'b1;
              addrD = iAddr1;
              dataD = iData1;
            end
          end
        end
        default: stateD = StInit;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      stateQ   <= StInit;
      fillCntQ <= '0;
      ptrQ     <= 1'b1;
      enQ      <= 1'b0;
      addrQ    <= '0;
      dataQ    <= '0;
    end else begin
      stateQ   <= stateD;
      fillCntQ <= fillCntD;
      ptrQ     <= ptrD;
      enQ      <= enD;
      addrQ    <= addrD;
      dataQ    <= dataD;
    end
  end

  assign oEnWrite   = enQ;
  assign oAddrWrite = addrQ;
  assign oDataWrite = dataQ;
  assign oInitDone  = run;

endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed bench for regfile_write_sched: every write seen on the port is popped from a
// scoreboard of expected {addr, data} pairs; handshakes and flags are checked inline.
module tb_regfile_write_sched;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NREG = 2 ** AW;

  logic          iClk = 1'b0;
  logic          iRst_n;
  logic          iReinit;
  logic          iValid0, iValid1;
  logic [AW-1:0] iAddr0, iAddr1;
  logic [DW-1:0] iData0, iData1;
  logic          oReady0, oReady1;
  logic          oEnWrite;
  logic [AW-1:0] oAddrWrite;
  logic [DW-1:0] oDataWrite;
  logic          oInitDone;

  int total = 0;
  int bad   = 0;
  logic [AW+DW-1:0] sb[$];

  regfile_write_sched #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .iClk       (iClk),
    .iRst_n     (iRst_n),
    .iReinit    (iReinit),
    .iValid0    (iValid0),
    .iAddr0     (iAddr0),
    .iData0     (iData0),
    .oReady0    (oReady0),
    .iValid1    (iValid1),
    .iAddr1     (iAddr1),
    .iData1     (iData1),
    .oReady1    (oReady1),
    .oEnWrite   (oEnWrite),
    .oAddrWrite (oAddrWrite),
    .oDataWrite (oDataWrite),
    .oInitDone  (oInitDone)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushFill(input int unsigned first, input int unsigned last);
    for (int a = first; a <= last; a++) begin
      logic [AW-1:0] ad;
      ad = AW'(a);
      sb.push_back({ad, {DW{1'b0}}});
    end
  endtask

  task automatic edge1();
    @(posedge iClk);
    #1;
  endtask

  // Scoreboard: every registered write must match the oldest expected entry.
  always @(negedge iClk) begin
    if (iRst_n === 1'b1 && oEnWrite === 1'b1) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_write observed=%0h expected=none", {oAddrWrite, oDataWrite});
      end
      if (sb.size() != 0) begin
        logic [AW+DW-1:0] e;
        e = sb.pop_front();
        check("write_port", 64'({oAddrWrite, oDataWrite}), 64'(e));
      end
    end
  end

  initial begin
    logic mPtr;
    int   g0, g1;
    iRst_n = 1'b0; iReinit = 1'b0;
    iValid0 = 1'b1; iValid1 = 1'b1;
    iAddr0 = '0; iAddr1 = '0; iData0 = '0; iData1 = '0;
    #7;
    check("rst_en", 64'(oEnWrite), 64'(0));
    check("rst_addr", 64'(oAddrWrite), 64'(0));
    check("rst_data", 64'(oDataWrite), 64'(0));
    check("rst_done", 64'(oInitDone), 64'(0));
    check("rst_rdy0", 64'(oReady0), 64'(0));
    check("rst_rdy1", 64'(oReady1), 64'(0));

    // Zero-fill after reset; requesters held valid to show they are stalled.
    pushFill(0, NREG - 1);
    @(negedge iClk);
    iRst_n = 1'b1;
    for (int k = 1; k <= int'(NREG); k++) begin
      edge1();
      check("init_rdy0", 64'(oReady0), 64'(0));
      check("init_rdy1", 64'(oReady1), 64'(0));
      check("init_done", 64'(oInitDone), 64'(0));
      if (k == 1) check("init_first_addr", 64'(oAddrWrite), 64'(0));
    end
    iValid0 = 1'b0; iValid1 = 1'b0;
    edge1();
    check("init_end_en", 64'(oEnWrite), 64'(0));
    check("init_end_done", 64'(oInitDone), 64'(1));
    check("init_sb_empty", 64'(sb.size()), 64'(0));

    // Round-robin with both valid, starting from the reset pointer.
    mPtr = 1'b1; g0 = 0; g1 = 0;
    iValid0 = 1'b1; iAddr0 = 5'd3; iData0 = 32'h1;
    iValid1 = 1'b1; iAddr1 = 5'd7; iData1 = 32'h2;
    for (int c = 0; c < 8; c++) begin
      #1;
      check("rr_rdy0", 64'(oReady0), 64'(mPtr));
      check("rr_rdy1", 64'(oReady1), 64'(!mPtr));
      if (mPtr) begin sb.push_back({5'd3, 32'h1}); g0++; end
      else      begin sb.push_back({5'd7, 32'h2}); g1++; end
      mPtr = !mPtr;
      edge1();
    end
    iValid0 = 1'b0; iValid1 = 1'b0;
    check("rr_share0", 64'(g0), 64'(4));
    check("rr_share1", 64'(g1), 64'(4));
    edge1();

    // Single ALU write.
    iValid0 = 1'b1; iAddr0 = 5'd5; iData0 = 32'hDEAD_BEEF;
    #1;
    check("single_rdy0", 64'(oReady0), 64'(1));
    check("single_rdy1", 64'(oReady1), 64'(0));
    sb.push_back({5'd5, 32'hDEAD_BEEF});
    edge1();
    iValid0 = 1'b0;
    check("single_en", 64'(oEnWrite), 64'(1));
    check("single_addr", 64'(oAddrWrite), 64'(5));
    check("single_data", 64'(oDataWrite), 64'(32'hDEAD_BEEF));
    edge1();
    check("single_en_drop", 64'(oEnWrite), 64'(0));
    check("single_addr_hold", 64'(oAddrWrite), 64'(5));

    // Write to r0 handshakes but never reaches the file.
    iValid1 = 1'b1; iAddr1 = 5'd0; iData1 = 32'hFFFF_FFFF;
    #1;
    check("r0_rdy1", 64'(oReady1), 64'(1));
    edge1();
    iValid1 = 1'b0;
    check("r0_en", 64'(oEnWrite), 64'(0));
    edge1();

    // Reinit on the same edge as an accepted transfer to r9.
    iValid0 = 1'b1; iAddr0 = 5'd9; iData0 = 32'h1234_5678; iReinit = 1'b1;
    #1;
    check("reinit_rdy0", 64'(oReady0), 64'(1));
    pushFill(0, NREG - 1);
    edge1();
    iReinit = 1'b0; iValid0 = 1'b0;
    check("reinit_en", 64'(oEnWrite), 64'(1));
    check("reinit_addr", 64'(oAddrWrite), 64'(0));
    check("reinit_done", 64'(oInitDone), 64'(0));
    for (int k = 1; k < int'(NREG); k++) edge1();
    check("refill_last_addr", 64'(oAddrWrite), 64'(NREG - 1));
    check("refill_last_done", 64'(oInitDone), 64'(0));
    edge1();
    check("refill_done", 64'(oInitDone), 64'(1));
    check("refill_sb_empty", 64'(sb.size()), 64'(0));

    // Async reset in the middle of a fill, right after address 12 is issued.
    iReinit = 1'b1;
    pushFill(0, 11);
    edge1();
    iReinit = 1'b0;
    for (int k = 1; k <= 12; k++) edge1();
    check("mid_addr12", 64'(oAddrWrite), 64'(12));
    check("mid_sb_empty", 64'(sb.size()), 64'(0));
    #1;
    iRst_n = 1'b0;
    #1;
    check("arst_en", 64'(oEnWrite), 64'(0));
    check("arst_addr", 64'(oAddrWrite), 64'(0));
    check("arst_data", 64'(oDataWrite), 64'(0));
    check("arst_done", 64'(oInitDone), 64'(0));
    pushFill(0, NREG - 1);
    @(negedge iClk);
    iRst_n = 1'b1;
    edge1();
    check("arst_restart_addr", 64'(oAddrWrite), 64'(0));
    check("arst_restart_en", 64'(oEnWrite), 64'(1));
    for (int k = 2; k <= int'(NREG) + 1; k++) edge1();
    check("arst_refill_done", 64'(oInitDone), 64'(1));
    edge1();
    check("final_sb_empty", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
